// File: rtl/addsub_nibble_serial_if.sv
// Start/done request and result bus for the nibble-serial saturating adder/subtractor.
interface addsub_nibble_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Z;
    logic             V;
    logic             N;

    modport master (
        output start, A, B, sub,
        input  busy, done, Sum, Z, V, N
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, Sum, Z, V, N
    );
endinterface

// File: rtl/addsub_nibble_serial.sv
// 16-bit saturating add/sub, one 4-bit nibble per clock with a chained carry register.
module addsub_nibble_serial #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addsub_nibble_serial_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [WIDTH-5:0] part_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             z_q;
    logic             v_q;
    logic             n_q;

    logic             last_nib;
    logic [3:0]       b_eff;
    logic [4:0]       nib_sum;
    logic [3:0]       low3;
    logic             ovf;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat;

    // Next-state logic: IDLE -> CALC on start, CALC for NIB nibbles, one cycle in DONE.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (last_nib) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // Nibble slice; low3 recovers the carry into the result MSB on the top nibble.
    always_comb begin
        last_nib = (count_q == CW'(NIB - 1));
        b_eff    = sub_q ? ~b_q[3:0] : b_q[3:0];
        nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_eff} + 5'(carry_q);
        low3     = {1'b0, a_q[2:0]} + {1'b0, b_eff[2:0]} + 4'(carry_q);
        ovf      = low3[3] ^ nib_sum[4];
        raw      = {nib_sum[3:0], part_q};
        if (ovf) sat = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        else     sat = raw;
    end

    // Datapath: operand latch, nibble shifting, and result/flag capture at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            part_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub;
                        count_q <= '0;
                    end
                end
                CALC: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    part_q  <= {nib_sum[3:0], part_q[WIDTH-5:4]};
                    carry_q <= nib_sum[4];
                    count_q <= count_q + CW'(1);
                    if (last_nib) begin
                        sum_q <= sat;
                        z_q   <= (sat == '0);
                        v_q   <= ovf;
                        n_q   <= sat[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
    assign bus.N    = n_q;
endmodule
